// File: rtl/number_encode_mod_pkg.sv
// Shared constants for the binary-to-7-segment converter: segment codes, state encoding, saturation limit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package number_encode_mod_pkg;

    // Active-low segment patterns, bit 7 = DP (kept off), bits 6..0 = g..a.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Largest value two decimal digits can show; anything above is clamped to it.
    localparam int unsigned SAT_LIMIT = 99;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 when doubled.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/number_encode_mod_if.sv
// Request/result bundle between the count source, the converter and the scan stage.
// Latency: n/a (wiring only).
// Backpressure: none; Start_Sig is dropped unless the converter is idle.
// Ports: Start_Sig/Number (request), Busy_Sig/Done_Sig/Ovf_Sig (status), ten_encode/one_encode (segments).
interface number_encode_mod_if #(
    parameter int BIN_WIDTH = 7
);
    logic                 Start_Sig;
    logic [BIN_WIDTH-1:0] Number;
    logic                 Busy_Sig;
    logic                 Done_Sig;
    logic                 Ovf_Sig;
    logic [7:0]           ten_encode;
    logic [7:0]           one_encode;

    // Requester side: drives the request, observes status and segment patterns.
    modport master (
        output Start_Sig, Number,
        input  Busy_Sig, Done_Sig, Ovf_Sig, ten_encode, one_encode
    );

    // Converter side.
    modport slave (
        input  Start_Sig, Number,
        output Busy_Sig, Done_Sig, Ovf_Sig, ten_encode, one_encode
    );
endinterface

// File: rtl/number_encode_mod_seg7_digit_encode.sv
// Maps one BCD digit to its active-low 7-segment pattern; non-decimal codes show blank.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (4-bit digit in), seg (8-bit pattern out, bit 7 = DP).
module seg7_digit_encode
    import number_encode_mod_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/number_encode_mod.sv
// Binary count -> two-digit 7-segment patterns via a one-bit-per-clock double-dabble engine.
// Latency: Done_Sig and new patterns BIN_WIDTH+1 edges after the accepting edge.
// Backpressure: none; Start_Sig outside IDLE is dropped, results hold until the next conversion.
// Ports: CLK, RST (sync, active-high), bus (slave side of number_encode_mod_if).
module number_encode_mod
    import number_encode_mod_pkg::*;
#(
    parameter int BIN_WIDTH  = 7,
    parameter bit BLANK_LEAD = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    number_encode_mod_if.slave   bus
);

    localparam int         CNT_W   = $clog2(BIN_WIDTH + 1);
    localparam logic [7:0] TEN_RST = BLANK_LEAD ? SEG_BLANK : SEG_0;

    conv_state_t          state_q, state_d;
    logic [BIN_WIDTH-1:0] bin_q;
    logic [7:0]           bcd_q;
    logic [7:0]           bcd_adj;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ovf_cap_q;
    logic [7:0]           ten_q, one_q;
    logic                 ovf_q, done_q;

    logic                 num_ovf;
    logic [BIN_WIDTH-1:0] num_clamped;
    logic [7:0]           seg_ten, seg_one, ten_pat;

    // Widen before comparing so narrow BIN_WIDTH settings still compare against 99 correctly.
    assign num_ovf     = 16'(bus.Number) > 16'(SAT_LIMIT);
    assign num_clamped = num_ovf ? BIN_WIDTH'(SAT_LIMIT) : bus.Number;

    assign bcd_adj = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};

    seg7_digit_encode u_ten_enc (.bcd(bcd_q[7:4]), .seg(seg_ten));
    seg7_digit_encode u_one_enc (.bcd(bcd_q[3:0]), .seg(seg_one));

    assign ten_pat = (BLANK_LEAD && (bcd_q[7:4] == 4'd0)) ? SEG_BLANK : seg_ten;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.Start_Sig) state_d = ST_SHIFT;
            // cnt_q == 1 means this edge performs the final shift.
            ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Conversion datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            ovf_cap_q <= 1'b0;
            ten_q     <= TEN_RST;
            one_q     <= SEG_0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (bus.Start_Sig) begin
                        bin_q     <= num_clamped;
                        bcd_q     <= '0;
                        cnt_q     <= CNT_W'(BIN_WIDTH);
                        ovf_cap_q <= num_ovf;
                    end
                end
                ST_SHIFT: begin
                    // Correct first, then shift {bcd, bin} left one place.
                    bcd_q <= {bcd_adj[6:0], bin_q[BIN_WIDTH-1]};
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_DONE: begin
                    ten_q <= ten_pat;
                    one_q <= seg_one;
                    ovf_q <= ovf_cap_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy_Sig   = (state_q == ST_SHIFT);
    assign bus.Done_Sig   = done_q;
    assign bus.Ovf_Sig    = ovf_q;
    assign bus.ten_encode = ten_q;
    assign bus.one_encode = one_q;

endmodule
